// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit saturating-counter branch predictor with branch/mispredict counters.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_br_en,
  input  logic                upd_pred_taken,
  input  logic [IDX_BITS-1:0] upd_ghr,
  output logic                mispredict,
  output logic [31:0]         br_count,
  output logic [31:0]         mp_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          table_q [ENTRIES];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [1:0]          upd_old;
  logic [1:0]          upd_new;
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         mp_count_q, mp_count_d;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                            upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q, ghr_d;

  assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr_q;
  assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ upd_ghr;
  assign pred_ghr = ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[IDX_BITS-2:0], upd_br_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  logic unused_ghr;
  assign unused_ghr = ^upd_ghr;

  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign pred_ghr = '0;
`endif

  // Lookup reads the registered table, so a same-cycle update shows up next cycle.
  assign pred_taken = table_q[pred_idx][1];
  assign mispredict = upd_valid && (upd_pred_taken != upd_br_en);

  always_comb begin
    upd_old = table_q[upd_idx];
    upd_new = upd_old;
    if (upd_br_en) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
    end
  end

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (upd_valid)  br_count_d = br_count_q + 32'd1;
    if (mispredict) mp_count_d = mp_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (upd_valid) table_q[upd_idx] <= upd_new;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [5:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_en;
  logic        upd_pred_taken;
  logic [5:0]  upd_ghr;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_predictor #(.IDX_BITS(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_br_en      (upd_br_en),
    .upd_pred_taken (upd_pred_taken),
    .upd_ghr        (upd_ghr),
    .mispredict     (mispredict),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; pred_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
    upd_br_en = 1'b0; upd_pred_taken = 1'b0; upd_ghr = '0;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred actual=%b required=0", pred_taken); end
    n_cmp++; if (pred_ghr !== 6'd0) begin n_fail++; $display("FAIL reset_ghr actual=%0d required=0", pred_ghr); end
    n_cmp++; if (br_count !== 32'd0) begin n_fail++; $display("FAIL reset_br_count actual=%0d required=0", br_count); end
    n_cmp++; if (mp_count !== 32'd0) begin n_fail++; $display("FAIL reset_mp_count actual=%0d required=0", mp_count); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entry 0 walks 01->10->11->11 then 11->10->01->00; values checked before each edge.
  task automatic test_counter_walk;
    logic [5:0] exp_pred = 6'b011110;
    logic [5:0] br       = 6'b000111;
    logic [5:0] exp_mp   = 6'b011001;
    pred_pc = 32'h100; upd_pc = 32'h100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_br_en = br[i]; upd_pred_taken = exp_pred[i];
      #1;
      n_cmp++; if (pred_taken !== exp_pred[i]) begin n_fail++; $display("FAIL walk_pred[%0d] actual=%b required=%b", i, pred_taken, exp_pred[i]); end
      n_cmp++; if (mispredict !== exp_mp[i]) begin n_fail++; $display("FAIL walk_mispredict[%0d] actual=%b required=%b", i, mispredict, exp_mp[i]); end
    end
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL walk_final_pred actual=%b required=0", pred_taken); end
    n_cmp++; if (br_count !== 32'd6) begin n_fail++; $display("FAIL walk_br_count actual=%0d required=6", br_count); end
    n_cmp++; if (mp_count !== 32'd3) begin n_fail++; $display("FAIL walk_mp_count actual=%0d required=3", mp_count); end
  endtask

  // 0x200 aliases onto entry 0 (now 00); two taken updates make 0x100 predict taken.
  task automatic test_alias;
    pred_pc = 32'h100; upd_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); upd_valid = 1'b1; upd_br_en = 1'b1; upd_pred_taken = 1'b0;
    end
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_pred actual=%b required=1", pred_taken); end
    n_cmp++; if (mp_count !== 32'd5) begin n_fail++; $display("FAIL alias_mp_count actual=%0d required=5", mp_count); end
  endtask

  task automatic test_same_cycle;
    @(negedge clk);
    pred_pc = 32'h104; upd_pc = 32'h104;
    upd_valid = 1'b1; upd_br_en = 1'b1; upd_pred_taken = 1'b0;
    #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre actual=%b required=0", pred_taken); end
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_cycle_post actual=%b required=1", pred_taken); end
    n_cmp++; if (br_count !== 32'd9) begin n_fail++; $display("FAIL same_cycle_br_count actual=%0d required=9", br_count); end
  endtask

  task automatic test_idle;
    @(negedge clk);
    pred_pc = 32'h104; upd_pc = 32'h104;
    upd_valid = 1'b0; upd_br_en = 1'b0; upd_pred_taken = 1'b1;
    #1;
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL idle_mispredict actual=%b required=0", mispredict); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL idle_pred actual=%b required=1", pred_taken); end
    n_cmp++; if (br_count !== 32'd9) begin n_fail++; $display("FAIL idle_br_count actual=%0d required=9", br_count); end
    n_cmp++; if (mp_count !== 32'd6) begin n_fail++; $display("FAIL idle_mp_count actual=%0d required=6", mp_count); end
  endtask

  // Two taken edges take entry 2 from 01 to 11, so one not-taken still leaves it taken.
  task automatic test_back_to_back;
    pred_pc = 32'h108; upd_pc = 32'h108;
    @(negedge clk); upd_valid = 1'b1; upd_br_en = 1'b1; upd_pred_taken = 1'b1;
    @(negedge clk); upd_valid = 1'b1; upd_br_en = 1'b1; upd_pred_taken = 1'b1;
    @(negedge clk); upd_valid = 1'b1; upd_br_en = 1'b0; upd_pred_taken = 1'b0;
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_pred actual=%b required=1", pred_taken); end
    n_cmp++; if (br_count !== 32'd12) begin n_fail++; $display("FAIL b2b_br_count actual=%0d required=12", br_count); end
    n_cmp++; if (mp_count !== 32'd6) begin n_fail++; $display("FAIL b2b_mp_count actual=%0d required=6", mp_count); end
  endtask

  task automatic test_reset_midstream;
    logic [31:0] pcs [4] = '{32'h100, 32'h104, 32'h108, 32'h200};
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h104; upd_br_en = 1'b1; upd_pred_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (br_count !== 32'd0) begin n_fail++; $display("FAIL midreset_br_count actual=%0d required=0", br_count); end
    n_cmp++; if (mp_count !== 32'd0) begin n_fail++; $display("FAIL midreset_mp_count actual=%0d required=0", mp_count); end
    for (int i = 0; i < 4; i++) begin
      pred_pc = pcs[i]; #1;
      n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midreset_pred[%0h] actual=%b required=0", pcs[i], pred_taken); end
    end
    @(negedge clk); #1;
    n_cmp++; if (br_count !== 32'd0) begin n_fail++; $display("FAIL midreset_held_br_count actual=%0d required=0", br_count); end
    pred_pc = 32'h104;
    rst_n = 1'b1;
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (br_count !== 32'd1) begin n_fail++; $display("FAIL first_upd_br_count actual=%0d required=1", br_count); end
    n_cmp++; if (mp_count !== 32'd1) begin n_fail++; $display("FAIL first_upd_mp_count actual=%0d required=1", mp_count); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL first_upd_pred actual=%b required=1", pred_taken); end
  endtask

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  // History T,NT,T -> 000101; an update of 0x100 with that snapshot lands on entry 5,
  // then history 001011 means lookup of entry 5 needs base 14 (pc 0x38).
  task automatic test_gshare;
    logic [2:0] br       = 3'b101;
    logic [5:0] ghr_snap [3] = '{6'd0, 6'd1, 6'd2};
    upd_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_br_en = br[i]; upd_pred_taken = 1'b0; upd_ghr = ghr_snap[i];
      #1;
      n_cmp++; if (pred_ghr !== ghr_snap[i]) begin n_fail++; $display("FAIL gshare_ghr[%0d] actual=%b required=%b", i, pred_ghr, ghr_snap[i]); end
    end
    @(negedge clk); upd_valid = 1'b0; #1;
    n_cmp++; if (pred_ghr !== 6'b000101) begin n_fail++; $display("FAIL gshare_ghr_final actual=%b required=000101", pred_ghr); end
    upd_valid = 1'b1; upd_pc = 32'h100; upd_br_en = 1'b1; upd_ghr = 6'b000101;
    @(negedge clk); upd_valid = 1'b0; #1;
    pred_pc = 32'h38; #1;
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL gshare_entry5 actual=%b required=1", pred_taken); end
    pred_pc = 32'h14; #1;
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL gshare_entry14 actual=%b required=0", pred_taken); end
  endtask
`else
  task automatic test_ghr_tied;
    @(negedge clk); #1;
    n_cmp++; if (pred_ghr !== 6'd0) begin n_fail++; $display("FAIL ghr_tied actual=%b required=0", pred_ghr); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    test_gshare;
`else
    test_counter_walk;
    test_alias;
    test_same_cycle;
    test_idle;
    test_back_to_back;
    test_ghr_tied;
    test_reset_midstream;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
